// File: rtl/clock_time_counter.sv
`default_nettype none
// ============================================================================
//  Module      : clock_time_counter
//  Description : BCD MM.SS timekeeper (00.00 .. 99.59) for a 4-digit display.
//                Divides the system clock to a seconds tick, with run/stop,
//                clear and manual minute/second increment controls.
//  Revision    : 1.0 - initial release
// ============================================================================
module clock_time_counter #(
  parameter int TICK_DIV = 50_000_000,
  parameter int SYNC_STG = 2
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       run_en,
  input  logic       clr,
  input  logic       inc_sec,
  input  logic       inc_min,
  output logic [3:0] dig1_cntr,
  output logic [3:0] dig2_cntr,
  output logic [3:0] dig3_cntr,
  output logic [3:0] dig4_cntr,
  output logic       tick_1hz,
  output logic       rollover
);

  localparam int              PRE_W   = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_TOP = PRE_W'(TICK_DIV - 1);

  // Synchroniser chains; the MSB of each chain is the usable, synced level.
  logic [SYNC_STG-1:0] run_sync;
  logic [SYNC_STG-1:0] clr_sync;
  logic [SYNC_STG-1:0] sec_sync;
  logic [SYNC_STG-1:0] min_sync;

  // Previous synced level of each event input, for rising-edge detection.
  logic clr_prev;
  logic sec_prev;
  logic min_prev;

  logic             run_s;
  logic             clr_edge;
  logic             sec_edge;
  logic             min_edge;
  logic             tick_due;

  logic [PRE_W-1:0] pre_cnt;
  logic [PRE_W-1:0] pre_n;

  logic       sec_carry;
  logic       min_carry;
  logic [3:0] sec_u_inc;
  logic [3:0] sec_t_inc;
  logic [3:0] min_u_inc;
  logic [3:0] min_t_inc;

  logic [3:0] d1_n;
  logic [3:0] d2_n;
  logic [3:0] d3_n;
  logic [3:0] d4_n;
  logic       tick_n;
  logic       roll_n;

  assign run_s    = run_sync[SYNC_STG-1];
  assign clr_edge = clr_sync[SYNC_STG-1] & ~clr_prev;
  assign sec_edge = sec_sync[SYNC_STG-1] & ~sec_prev;
  assign min_edge = min_sync[SYNC_STG-1] & ~min_prev;
  assign tick_due = run_s && (pre_cnt == PRE_TOP);

  // Bring the asynchronous board inputs into the clock domain and keep the
  // last synced level for edge detection.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      run_sync <= '0;
      clr_sync <= '0;
      sec_sync <= '0;
      min_sync <= '0;
      clr_prev <= 1'b0;
      sec_prev <= 1'b0;
      min_prev <= 1'b0;
    end else begin
      run_sync <= {run_sync[SYNC_STG-2:0], run_en};
      clr_sync <= {clr_sync[SYNC_STG-2:0], clr};
      sec_sync <= {sec_sync[SYNC_STG-2:0], inc_sec};
      min_sync <= {min_sync[SYNC_STG-2:0], inc_min};
      clr_prev <= clr_sync[SYNC_STG-1];
      sec_prev <= sec_sync[SYNC_STG-1];
      min_prev <= min_sync[SYNC_STG-1];
    end
  end

  // Single-step BCD increments of the seconds pair (00..59) and minutes pair (00..99).
  always_comb begin
    sec_carry = (dig1_cntr == 4'd9) && (dig2_cntr == 4'd5);
    min_carry = (dig3_cntr == 4'd9) && (dig4_cntr == 4'd9);
    sec_u_inc = (dig1_cntr == 4'd9) ? 4'd0 : dig1_cntr + 4'd1;
    sec_t_inc = dig2_cntr;
    if (dig1_cntr == 4'd9) begin
      sec_t_inc = (dig2_cntr == 4'd5) ? 4'd0 : dig2_cntr + 4'd1;
    end
    min_u_inc = (dig3_cntr == 4'd9) ? 4'd0 : dig3_cntr + 4'd1;
    min_t_inc = dig4_cntr;
    if (dig3_cntr == 4'd9) begin
      min_t_inc = (dig4_cntr == 4'd9) ? 4'd0 : dig4_cntr + 4'd1;
    end
  end

  // Next-state selection: clear beats manual increments, which beat the tick.
  always_comb begin
    d1_n   = dig1_cntr;
    d2_n   = dig2_cntr;
    d3_n   = dig3_cntr;
    d4_n   = dig4_cntr;
    tick_n = 1'b0;
    roll_n = 1'b0;
    pre_n  = pre_cnt;
    // The prescaler keeps wrapping even when a manual increment swallows the tick.
    if (run_s) begin
      pre_n = tick_due ? '0 : pre_cnt + 1'b1;
    end
    if (clr_edge) begin
      d1_n  = 4'd0;
      d2_n  = 4'd0;
      d3_n  = 4'd0;
      d4_n  = 4'd0;
      pre_n = '0;
    end else if (sec_edge || min_edge) begin
      if (sec_edge) begin
        d1_n = sec_u_inc;
        d2_n = sec_t_inc;
      end
      if (min_edge) begin
        d3_n = min_u_inc;
        d4_n = min_t_inc;
      end
    end else if (tick_due) begin
      tick_n = 1'b1;
      d1_n   = sec_u_inc;
      d2_n   = sec_t_inc;
      if (sec_carry) begin
        d3_n   = min_u_inc;
        d4_n   = min_t_inc;
        roll_n = min_carry;
      end
    end
  end

  // Time, prescaler and registered tick/rollover pulses.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      pre_cnt   <= '0;
      dig1_cntr <= 4'd0;
      dig2_cntr <= 4'd0;
      dig3_cntr <= 4'd0;
      dig4_cntr <= 4'd0;
      tick_1hz  <= 1'b0;
      rollover  <= 1'b0;
    end else begin
      pre_cnt   <= pre_n;
      dig1_cntr <= d1_n;
      dig2_cntr <= d2_n;
      dig3_cntr <= d3_n;
      dig4_cntr <= d4_n;
      tick_1hz  <= tick_n;
      rollover  <= roll_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_clock_time_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clock_time_counter
//  Description : Self-checking bench for clock_time_counter (TICK_DIV=4,
//                SYNC_STG=2) with directed scenarios and random stimulus
//                compared against a total-seconds reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_time_counter;

  localparam int TICK_DIV = 4;
  localparam int SYNC_STG = 2;

  logic       CLOCK_50;
  logic       RESET_N;
  logic       run_en;
  logic       clr;
  logic       inc_sec;
  logic       inc_min;
  logic [3:0] dig1_cntr;
  logic [3:0] dig2_cntr;
  logic [3:0] dig3_cntr;
  logic [3:0] dig4_cntr;
  logic       tick_1hz;
  logic       rollover;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  clock_time_counter #(
    .TICK_DIV(TICK_DIV),
    .SYNC_STG(SYNC_STG)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .run_en   (run_en),
    .clr      (clr),
    .inc_sec  (inc_sec),
    .inc_min  (inc_min),
    .dig1_cntr(dig1_cntr),
    .dig2_cntr(dig2_cntr),
    .dig3_cntr(dig3_cntr),
    .dig4_cntr(dig4_cntr),
    .tick_1hz (tick_1hz),
    .rollover (rollover)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  // Reference model: time held as minutes/seconds integers, inputs seen
  // through a plain delay line of raw samples.
  typedef struct {
    int sec;
    int min;
    int pre;
    bit tick;
    bit roll;
  } model_t;

  model_t              m;
  logic [SYNC_STG:0]   h_run;
  logic [SYNC_STG:0]   h_clr;
  logic [SYNC_STG:0]   h_sec;
  logic [SYNC_STG:0]   h_min;

  function automatic model_t model_next(model_t cur, bit run_s, bit c, bit is, bit im);
    model_t nx;
    bit     wrap;
    int     total;
    nx      = cur;
    nx.tick = 1'b0;
    nx.roll = 1'b0;
    wrap    = run_s && (cur.pre == TICK_DIV - 1);
    if (run_s) nx.pre = (cur.pre + 1) % TICK_DIV;
    if (c) begin
      nx.sec = 0;
      nx.min = 0;
      nx.pre = 0;
    end else if (is || im) begin
      if (is) nx.sec = (cur.sec + 1) % 60;
      if (im) nx.min = (cur.min + 1) % 100;
    end else if (wrap) begin
      nx.tick = 1'b1;
      total   = cur.min * 60 + cur.sec + 1;
      if (total == 6000) begin
        nx.roll = 1'b1;
        total   = 0;
      end
      nx.sec = total % 60;
      nx.min = total / 60;
    end
    return nx;
  endfunction

  // Advance the reference model once per clock; reset clears it at once.
  always @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      m     <= '{sec: 0, min: 0, pre: 0, tick: 1'b0, roll: 1'b0};
      h_run <= '0;
      h_clr <= '0;
      h_sec <= '0;
      h_min <= '0;
    end else begin
      m <= model_next(m, h_run[SYNC_STG-1],
                      h_clr[SYNC_STG-1] & ~h_clr[SYNC_STG],
                      h_sec[SYNC_STG-1] & ~h_sec[SYNC_STG],
                      h_min[SYNC_STG-1] & ~h_min[SYNC_STG]);
      h_run <= {h_run[SYNC_STG-1:0], run_en};
      h_clr <= {h_clr[SYNC_STG-1:0], clr};
      h_sec <= {h_sec[SYNC_STG-1:0], inc_sec};
      h_min <= {h_min[SYNC_STG-1:0], inc_min};
    end
  end

  task automatic check_value(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge CLOCK_50) begin
    if (chk_en) begin
      check_value("model_dig1", int'(dig1_cntr), m.sec % 10);
      check_value("model_dig2", int'(dig2_cntr), m.sec / 10);
      check_value("model_dig3", int'(dig3_cntr), m.min % 10);
      check_value("model_dig4", int'(dig4_cntr), m.min / 10);
      check_value("model_tick", int'(tick_1hz), int'(m.tick));
      check_value("model_roll", int'(rollover), int'(m.roll));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic check_time(input string tag, input int mm, input int ss);
    check_value({tag, "_d1"}, int'(dig1_cntr), ss % 10);
    check_value({tag, "_d2"}, int'(dig2_cntr), ss / 10);
    check_value({tag, "_d3"}, int'(dig3_cntr), mm % 10);
    check_value({tag, "_d4"}, int'(dig4_cntr), mm / 10);
  endtask

  task automatic pulse(input bit s, input bit mn);
    inc_sec = s;
    inc_min = mn;
    step(1);
    inc_sec = 1'b0;
    inc_min = 1'b0;
    step(1);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    step(3);
  endtask

  // Returns at the negedge following the next tick_1hz pulse (bounded).
  task automatic wait_tick();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1);
      if (tick_1hz) seen = 1'b1;
    end
    if (!seen) check_value("tick_timeout", 0, 1);
  endtask

  initial begin
    int ticks;
    RESET_N = 1'b0;
    run_en  = 1'b0;
    clr     = 1'b0;
    inc_sec = 1'b0;
    inc_min = 1'b0;
    step(3);
    chk_en = 1'b1;
    check_time("reset", 0, 0);
    check_value("reset_tick", int'(tick_1hz), 0);
    check_value("reset_roll", int'(rollover), 0);

    // 1: free run from reset.
    RESET_N = 1'b1;
    run_en  = 1'b1;
    ticks   = 0;
    for (int i = 0; i < 42; i++) begin
      step(1);
      if (tick_1hz) ticks++;
    end
    check_time("run42", 0, 10);
    check_value("run42_ticks", ticks, 10);

    // 2: preload 99.58 and roll over.
    run_en = 1'b0;
    step(3);
    pulse_clr();
    check_time("clr_idle", 0, 0);
    for (int i = 0; i < 58; i++) pulse(1'b1, 1'b1);
    for (int i = 0; i < 41; i++) pulse(1'b0, 1'b1);
    step(3);
    check_time("preload", 99, 58);
    run_en = 1'b1;
    wait_tick();
    check_time("tick_9959", 99, 59);
    check_value("roll_first", int'(rollover), 0);
    wait_tick();
    check_time("tick_0000", 0, 0);
    check_value("roll_second", int'(rollover), 1);

    // 3: manual wraps.
    run_en = 1'b0;
    for (int i = 0; i < 59; i++) pulse(1'b1, 1'b0);
    step(3);
    check_time("sec59", 0, 59);
    pulse(1'b1, 1'b0);
    step(3);
    check_time("sec_wrap", 0, 0);
    for (int i = 0; i < 99; i++) pulse(1'b0, 1'b1);
    step(3);
    check_time("min99", 99, 0);
    pulse(1'b0, 1'b1);
    step(3);
    check_time("min_wrap", 0, 0);

    // 4: inc_sec lands on the tick cycle.
    run_en = 1'b1;
    wait_tick();
    check_time("t4_first", 0, 1);
    step(1);
    inc_sec = 1'b1;
    step(1);
    inc_sec = 1'b0;
    step(2);
    check_value("t4_tick_dropped", int'(tick_1hz), 0);
    check_time("t4_inc_only", 0, 2);
    wait_tick();
    check_time("t4_next", 0, 3);

    // 5: stop at prescaler 2, resume.
    run_en = 1'b0;
    ticks  = 0;
    for (int i = 0; i < 22; i++) begin
      step(1);
      if (tick_1hz) ticks++;
    end
    check_value("t5_no_ticks", ticks, 0);
    check_time("t5_frozen", 0, 3);
    run_en = 1'b1;
    step(3);
    check_value("t5_not_yet", int'(tick_1hz), 0);
    step(1);
    check_value("t5_resume_tick", int'(tick_1hz), 1);
    check_time("t5_resumed", 0, 4);

    // 6: clr beats inc_min; async reset mid-count.
    run_en = 1'b0;
    step(3);
    pulse_clr();
    for (int i = 0; i < 12; i++) pulse(1'b1, 1'b1);
    for (int i = 0; i < 22; i++) pulse(1'b1, 1'b0);
    step(3);
    check_time("t6_1234", 12, 34);
    clr     = 1'b1;
    inc_min = 1'b1;
    step(1);
    clr     = 1'b0;
    inc_min = 1'b0;
    step(3);
    check_time("t6_clr_wins", 0, 0);
    run_en = 1'b1;
    step(13);
    check_time("t6_counting", 0, 2);
    #2 RESET_N = 1'b0;
    #1;
    check_time("t6_async_rst", 0, 0);
    check_value("t6_rst_tick", int'(tick_1hz), 0);
    check_value("t6_rst_roll", int'(rollover), 0);
    step(2);
    RESET_N = 1'b1;

    // Random phase.
    run_en = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      step(1);
      if ($urandom_range(0, 15) == 0) run_en = ($urandom_range(0, 3) != 0);
      clr     = ($urandom_range(0, 99) == 0);
      inc_sec = ($urandom_range(0, 5) == 0);
      inc_min = ($urandom_range(0, 4) == 0);
      if (i == 2000) begin
        #3 RESET_N = 1'b0;
        step(2);
        RESET_N = 1'b1;
      end
    end
    step(2);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
